// File: rtl/pwm_audio_pkg.sv
// Shared constants and types for the PWM audio encoder/decoder pair.
// Both sides derive the PWM period from the same sample width.
package pwm_audio_pkg;

  localparam int PWM_SAMPLE_W = 8;
  localparam int PWM_PERIOD   = 2 ** PWM_SAMPLE_W;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } dec_state_e;

  function automatic int pwm_period(input int sample_w);
    return 2 ** sample_w;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Depths below two are raised to two.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/pwm_sample_decoder.sv
// Recovers PCM samples from a PWM bit stream by counting high cycles over
// free-running PERIOD-cycle windows, with a one-entry valid/ready output.
module pwm_sample_decoder
  import pwm_audio_pkg::*;
#(
  parameter int SAMPLE_W    = PWM_SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_vld,
  input  logic                sample_out_rdy,
  output logic                frame_tick,
  output logic                saturated,
  output logic                overrun,
  output dec_state_e          state_dbg
);

  localparam int PERIOD = pwm_period(SAMPLE_W);
  localparam logic [SAMPLE_W-1:0] WIN_LAST    = SAMPLE_W'(PERIOD - 1);
  localparam logic [SAMPLE_W-1:0] WIN_PRELAST = SAMPLE_W'(PERIOD - 2);

  logic                pwm_sync;
  logic [SAMPLE_W-1:0] win_cnt;
  logic [SAMPLE_W:0]   acc;
  logic [SAMPLE_W:0]   acc_next;
  logic [SAMPLE_W-1:0] clipped;
  logic                clip;
  logic                win_last;
  logic                new_result;
  logic                xfer;
  dec_state_e          state;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pwm_in),
    .q    (pwm_sync)
  );

  // Handshake: sample_out/saturated are meaningful while sample_out_vld=1 and
  // stay frozen until a cycle with vld=1 and rdy=1, which is the transfer.
  // A result arriving on a transfer cycle replaces the departing sample; a
  // result arriving while full without a transfer is dropped (overrun).
  always_comb begin
    win_last   = (win_cnt == WIN_LAST);
    acc_next   = (win_cnt == '0) ? {{SAMPLE_W{1'b0}}, pwm_sync}
                                 : acc + {{SAMPLE_W{1'b0}}, pwm_sync};
    clip       = acc_next[SAMPLE_W];
    clipped    = clip ? '1 : acc_next[SAMPLE_W-1:0];
    new_result = win_last && (state == RUN);
    xfer       = sample_out_vld && sample_out_rdy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= WARMUP;
      win_cnt        <= '0;
      acc            <= '0;
      frame_tick     <= 1'b0;
      sample_out     <= '0;
      sample_out_vld <= 1'b0;
      saturated      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      win_cnt    <= win_cnt + 1'b1;
      acc        <= acc_next;
      // Registered one cycle early so the pulse lands on the window's last cycle.
      frame_tick <= (win_cnt == WIN_PRELAST);

      if (win_last && (state == WARMUP)) begin
        state <= RUN;
      end

      if (new_result && (!sample_out_vld || xfer)) begin
        sample_out     <= clipped;
        saturated      <= clip;
        sample_out_vld <= 1'b1;
      end else begin
        if (new_result) begin
          overrun <= 1'b1;
        end
        if (xfer) begin
          sample_out_vld <= 1'b0;
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Self-checking bench for pwm_sample_decoder: behavioural PWM source,
// vector table for steady levels, hand-written handshake/reset sequences.
module tb_pwm_sample_decoder;
  import pwm_audio_pkg::*;

  localparam int W      = PWM_SAMPLE_W;
  localparam int PERIOD = PWM_PERIOD;
  localparam int SYNC   = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         pwm_in;
  logic [W-1:0] sample_out;
  logic         sample_out_vld;
  logic         sample_out_rdy;
  logic         frame_tick;
  logic         saturated;
  logic         overrun;
  dec_state_e   state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  longint cyc = 0;

  logic [W:0] exp_q[$];

  // PWM source: mode 0 = duty from src_sample (latched at period start),
  // mode 1 = held low, mode 2 = held high.
  int           mode = 1;
  logic [W-1:0] src_sample = '0;
  logic [W-1:0] phase;
  logic [W-1:0] cur;

  assign pwm_in = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (phase < cur);

  pwm_sample_decoder #(
    .SAMPLE_W   (W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pwm_in        (pwm_in),
    .sample_out    (sample_out),
    .sample_out_vld(sample_out_vld),
    .sample_out_rdy(sample_out_rdy),
    .frame_tick    (frame_tick),
    .saturated     (saturated),
    .overrun       (overrun),
    .state_dbg     (state_dbg)
  );

  // Clock / reset block
  initial begin
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    phase = W'(77);
    cur   = '0;
    forever begin
      @(posedge clk);
      #1;
      phase = phase + 1'b1;
      if (phase == '0) cur = src_sample;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // Checking helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_compare(input string name);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      note_fail(name, "scoreboard empty at transfer");
    end else begin
      e = exp_q.pop_front();
      check(name, {23'b0, saturated, sample_out}, {23'b0, e});
    end
  endtask

  // Stops on the negedge before a transfer edge; caller then steps past it.
  task automatic find_xfer(input string name, output bit ok, output longint t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (sample_out_vld && sample_out_rdy) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) note_fail(name, "no transfer within cycle budget");
  endtask

  task automatic expect_xfer(input string name, output longint t);
    bit ok;
    find_xfer(name, ok, t);
    if (ok) sb_compare(name);
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    tick();
  endtask

  task automatic grab_xfer(input string name, output logic [W-1:0] s, output logic sat);
    bit ok;
    longint t;
    find_xfer(name, ok, t);
    s   = sample_out;
    sat = saturated;
    tick();
  endtask

  task automatic discard_xfers(input int n);
    logic [W-1:0] s;
    logic sat;
    for (int i = 0; i < n; i++) grab_xfer("settle", s, sat);
  endtask

  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) note_fail(name, "no frame_tick within cycle budget");
  endtask

  // Called at the negedge where reset drops; reports the cycle index
  // (1 = first cycle after release) during which vld is first high.
  task automatic measure_first_vld(input string name);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < 4 * PERIOD) begin
      @(posedge clk);
      k++;
      #1;
      if (sample_out_vld) seen = 1'b1;
    end
    if (!seen) note_fail(name, "vld never rose");
    else check(name, k + 1, 2 * PERIOD + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sample"},   {24'b0, sample_out}, 0);
    check({tag, "_vld"},      {31'b0, sample_out_vld}, 0);
    check({tag, "_frame"},    {31'b0, frame_tick}, 0);
    check({tag, "_sat"},      {31'b0, saturated}, 0);
    check({tag, "_overrun"},  {31'b0, overrun}, 0);
    check({tag, "_state"},    {31'b0, state_dbg}, {31'b0, WARMUP});
  endtask

  typedef struct {
    int           vmode;
    logic [W-1:0] src;
    logic [W-1:0] exp_sample;
    logic         exp_sat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    longint t, t_prev;
    logic [W-1:0] v0, v1;
    logic s0, s1;
    int n_mid;

    vecs[0] = '{0, 8'h80, 8'h80, 1'b0};
    vecs[1] = '{1, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{2, 8'h00, 8'hFF, 1'b1};
    vecs[3] = '{0, 8'hFF, 8'hFF, 1'b0};
    vecs[4] = '{0, 8'h01, 8'h01, 1'b0};
    vecs[5] = '{0, 8'h37, 8'h37, 1'b0};

    reset = 1'b1;
    sample_out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    reset = 1'b0;
    sample_out_rdy = 1'b1;
    measure_first_vld("first_vld_latency");
    check("run_state", {31'b0, state_dbg}, {31'b0, RUN});

    // Steady-level vectors, one result per window with rdy held high
    for (int v = 0; v < 6; v++) begin
      mode = vecs[v].vmode;
      src_sample = vecs[v].src;
      discard_xfers(3);
      t_prev = 0;
      for (int r = 0; r < 3; r++) begin
        exp_q.push_back({vecs[v].exp_sat, vecs[v].exp_sample});
        expect_xfer($sformatf("vec%0d_r%0d", v, r), t);
        if (r > 0) check($sformatf("vec%0d_interval", v), 32'(t - t_prev), PERIOD);
        t_prev = t;
      end
    end

    // rdy pulsed on the cycle a new result arrives
    mode = 2;
    discard_xfers(3);
    sample_out_rdy = 1'b0;
    wait_frame("pulse_frame_a");
    tick();
    check("pulse_held_a", {23'b0, saturated, sample_out}, {23'b0, 1'b1, 8'hFF});
    mode = 1;
    wait_frame("pulse_frame_b");
    sample_out_rdy = 1'b1;
    exp_q.push_back({1'b1, 8'hFF});
    sb_compare("pulse_old_xfer");
    tick();
    sample_out_rdy = 1'b0;
    check("pulse_vld_kept", {31'b0, sample_out_vld}, 1);
    check("pulse_new_loaded", {23'b0, saturated, sample_out}, {23'b0, 1'b0, 8'(SYNC)});
    check("pulse_no_overrun", {31'b0, overrun}, 0);
    sample_out_rdy = 1'b1;
    exp_q.push_back({1'b0, 8'(SYNC)});
    expect_xfer("pulse_new_xfer", t);

    // rdy low across two results: first held, second dropped
    mode = 0;
    src_sample = 8'h40;
    discard_xfers(3);
    sample_out_rdy = 1'b0;
    wait_frame("hold_frame_1");
    tick();
    check("hold_first", {23'b0, saturated, sample_out}, {23'b0, 1'b0, 8'h40});
    check("hold_no_overrun_yet", {31'b0, overrun}, 0);
    src_sample = 8'hF0;
    wait_frame("hold_frame_2");
    tick();
    check("hold_overrun_set", {31'b0, overrun}, 1);
    check("hold_kept_2", {23'b0, saturated, sample_out}, {23'b0, 1'b0, 8'h40});
    check("hold_vld", {31'b0, sample_out_vld}, 1);
    wait_frame("hold_frame_3");
    tick();
    check("hold_kept_3", {23'b0, saturated, sample_out}, {23'b0, 1'b0, 8'h40});
    sample_out_rdy = 1'b1;
    exp_q.push_back({1'b0, 8'h40});
    expect_xfer("hold_release", t);
    exp_q.push_back({1'b0, 8'hF0});
    expect_xfer("hold_next", t);
    check("overrun_sticky", {31'b0, overrun}, 1);

    // Reset mid-window with a held sample
    sample_out_rdy = 1'b0;
    wait_frame("midreset_frame");
    tick();
    repeat (100) tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sample_out_rdy = 1'b1;
    measure_first_vld("midreset_latency");

    // Source step 0x20 -> 0xC0 at a random phase
    mode = 0;
    src_sample = 8'h20;
    discard_xfers(3);
    repeat ($urandom_range(0, PERIOD - 1)) tick();
    src_sample = 8'hC0;
    grab_xfer("step_v0", v0, s0);
    grab_xfer("step_v1", v1, s1);
    n_mid = 0;
    if (v0 != 8'h20 && v0 != 8'hC0) n_mid++;
    if (v1 != 8'h20 && v1 != 8'hC0) n_mid++;
    check("step_intermediates", {31'b0, n_mid <= 1}, 1);
    check("step_order", {31'b0, !(v0 == 8'hC0 && v1 != 8'hC0)}, 1);
    check("step_no_sat", {30'b0, s0, s1}, 0);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back({1'b0, 8'hC0});
      expect_xfer($sformatf("step_steady%0d", r), t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
